frame_scan_ctrl: RTL

- Read-side sequencer for the cube frame buffer (byte-write / 32-bit-read dual-port RAM with a registered read address).
- Walks the display page word by word and presents each 32-bit word to the LED shift/PWM stage over a valid/ready handshake.
- Pauses at every line boundary until the driver acknowledges.
- Double-buffered: a CPU swap request flips the displayed page only at a frame boundary, so no frame tearing.

---
 rtl/frame_scan_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/frame_scan_ctrl.sv
// Read-side sequencer for the double-buffered cube frame buffer.
// Streams one page word by word to the LED driver and flips pages only at frame boundaries.
module frame_scan_ctrl #(
   parameter int ADDR_W     = 9,
   parameter int LINE_WORDS = 16
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_data,
   output logic [31:0]       pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              line_end,
   input  logic              line_ack,
   output logic              frame_end,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              disp_page
);

   localparam int IW = ADDR_W - 1;
   localparam int LB = $clog2(LINE_WORDS);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      LOAD,
      SEND,
      LWAIT
   } state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic          swap_pend;
   logic          last_line_word;
   logic          last_frame_word;

   assign ram_addr        = {disp_page, idx};
   assign last_line_word  = &idx[LB-1:0];
   assign last_frame_word = &idx;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         swap_pend <= 1'b0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         line_end  <= 1'b0;
         frame_end <= 1'b0;
         swap_ack  <= 1'b0;
         disp_page <= 1'b0;
      end else begin
         frame_end <= 1'b0;
         swap_ack  <= 1'b0;
         if (swap_req)
            swap_pend <= 1'b1;
         unique case (state)
            IDLE: begin
               if (enable) begin
                  idx   <= '0;
                  state <= PRIME;
               end
            end
            PRIME: state <= LOAD;
            LOAD: begin
               pix_data  <= ram_data;
               pix_valid <= 1'b1;
               line_end  <= last_line_word;
               state     <= SEND;
            end
            SEND: begin
               if (pix_ready) begin
                  pix_valid <= 1'b0;
                  line_end  <= 1'b0;
                  if (!last_line_word) begin
                     idx   <= idx + IDX_ONE;
                     state <= PRIME;
                  end else begin
                     // idx stays on the last word so LWAIT can spot frame end
                     if (!last_frame_word)
                        idx <= idx + IDX_ONE;
                     state <= LWAIT;
                  end
               end
            end
            LWAIT: begin
               if (line_ack) begin
                  if (last_frame_word) begin
                     frame_end <= 1'b1;
                     idx       <= '0;
                     // a request landing on this very cycle still counts
                     if (swap_pend || swap_req) begin
                        disp_page <= ~disp_page;
                        swap_ack  <= 1'b1;
                        swap_pend <= 1'b0;
                     end
                     state <= enable ? PRIME : IDLE;
                  end else begin
                     state <= PRIME;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
